// File: rtl/sensor_input_conditioner_pkg.sv
// Shared definitions for the panel switch input conditioner: channel bit order,
// debounce defaults and the water-level plausibility rule.
package sensor_input_conditioner_pkg;

    localparam int unsigned NUM_CHANNELS = 6;

    localparam int unsigned CH_LOW_WATER  = 0;
    localparam int unsigned CH_MID_WATER  = 1;
    localparam int unsigned CH_HIGH_WATER = 2;
    localparam int unsigned CH_EARTH_HUM  = 3;
    localparam int unsigned CH_AIR_HUM    = 4;
    localparam int unsigned CH_LOW_TEMP   = 5;

    localparam int unsigned DEFAULT_STABLE_TICKS = 4;
    localparam int unsigned DEFAULT_CNT_W        = 3;

    // Water sensors must read as a thermometer code: high implies mid implies low.
    function automatic logic water_plausible(input logic low, input logic mid, input logic high);
        return !((high && !mid) || (mid && !low) || (high && !low));
    endfunction

endpackage

// File: rtl/sensor_input_conditioner_debounce_channel.sv
// One debounced switch bit: two-flop synchroniser, tick-counted stability counter,
// clean level register and one-cycle change pulse.
module debounce_channel
    import sensor_input_conditioner_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = DEFAULT_STABLE_TICKS,
    parameter int unsigned CNT_W        = DEFAULT_CNT_W
) (
    input  logic clock,
    input  logic reset,
    input  logic sample_tick,
    input  logic raw,
    output logic clean,
    output logic pulse,
    output logic clean_next,
    output logic pulse_next,
    output logic idle_next
);

    localparam logic [CNT_W-1:0] LastCount = CNT_W'(STABLE_TICKS - 1);

    logic             sync1_q, sync2_q;
    logic             clean_q, clean_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        clean_d = clean_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (sync2_q == clean_q) begin
            // Any bounce back to the accepted level restarts the count.
            cnt_d = '0;
        end else if (sample_tick) begin
            if (cnt_q == LastCount) begin
                clean_d = sync2_q;
                cnt_d   = '0;
                pulse_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            clean_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            clean_q <= clean_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign clean      = clean_q;
    assign pulse      = pulse_q;
    assign clean_next = clean_d;
    assign pulse_next = pulse_d;
    // sync1_q is the next value of sync2_q.
    assign idle_next  = (sync1_q == clean_d) && (cnt_d == '0);

endmodule

// File: rtl/sensor_input_conditioner.sv
// Conditions the six raw panel switches: per-channel debounce plus the shared
// change, settled and water-level plausibility flags.
module sensor_input_conditioner
    import sensor_input_conditioner_pkg::*;
#(
    parameter int unsigned CHANNELS     = NUM_CHANNELS,
    parameter int unsigned STABLE_TICKS = DEFAULT_STABLE_TICKS,
    parameter int unsigned CNT_W        = DEFAULT_CNT_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                sample_tick,
    input  logic [CHANNELS-1:0] raw_in,
    output logic [CHANNELS-1:0] clean_out,
    output logic [CHANNELS-1:0] change_pulse,
    output logic                any_change,
    output logic                settled,
    output logic                level_plausible
);

    logic [CHANNELS-1:0] clean_next;
    logic [CHANNELS-1:0] pulse_next;
    logic [CHANNELS-1:0] idle_next;
    logic                any_change_q;
    logic                settled_q;
    logic                plausible_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .STABLE_TICKS(STABLE_TICKS),
            .CNT_W       (CNT_W)
        ) u_ch (
            .clock      (clock),
            .reset      (reset),
            .sample_tick(sample_tick),
            .raw        (raw_in[i]),
            .clean      (clean_out[i]),
            .pulse      (change_pulse[i]),
            .clean_next (clean_next[i]),
            .pulse_next (pulse_next[i]),
            .idle_next  (idle_next[i])
        );
    end

    // Flags are registered from next-state values so they line up with clean_out.
    always_ff @(posedge clock) begin
        if (reset) begin
            any_change_q <= 1'b0;
            settled_q    <= 1'b1;
            plausible_q  <= 1'b1;
        end else begin
            any_change_q <= |pulse_next;
            settled_q    <= &idle_next;
            plausible_q  <= water_plausible(clean_next[CH_LOW_WATER],
                                            clean_next[CH_MID_WATER],
                                            clean_next[CH_HIGH_WATER]);
        end
    end

    assign any_change      = any_change_q;
    assign settled         = settled_q;
    assign level_plausible = plausible_q;

endmodule

// File: tb/tb_sensor_input_conditioner.sv
// Self-checking bench: behavioural model compared every cycle, directed scenarios
// with literal expectations, then randomized stimulus.
module tb_sensor_input_conditioner;

    localparam int NCH = 6;
    localparam int ST  = 4;

    logic           clock = 1'b0;
    logic           reset;
    logic           sample_tick;
    logic [NCH-1:0] raw_in, clean_out, change_pulse;
    logic           any_change, settled, level_plausible;
    logic [NCH-1:0] raw2, clean2, pulse2;
    logic           any2, settled2, plaus2;

    always #5 clock = ~clock;

    sensor_input_conditioner dut (
        .clock          (clock),
        .reset          (reset),
        .sample_tick    (sample_tick),
        .raw_in         (raw_in),
        .clean_out      (clean_out),
        .change_pulse   (change_pulse),
        .any_change     (any_change),
        .settled        (settled),
        .level_plausible(level_plausible)
    );

    sensor_input_conditioner #(.STABLE_TICKS(1)) dut_fast (
        .clock          (clock),
        .reset          (reset),
        .sample_tick    (1'b1),
        .raw_in         (raw2),
        .clean_out      (clean2),
        .change_pulse   (pulse2),
        .any_change     (any2),
        .settled        (settled2),
        .level_plausible(plaus2)
    );

    int checks   = 0;
    int failures = 0;
    bit run_checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit thermo_ok(input logic [2:0] w);
        return (w == 3'b000) || (w == 3'b001) || (w == 3'b011) || (w == 3'b111);
    endfunction

    // Reference model: a new level is accepted once it has been seen on STABLE_TICKS
    // ticks without ever reverting; input reaches the debouncer two clocks late.
    logic [NCH-1:0] m_s1, m_s2, m_clean, m_pulse;
    int             m_ticks[NCH];
    bit             m_any, m_settled, m_plaus;
    logic [NCH-1:0] f_h0, f_h1, f_clean, f_pulse;
    bit             f_settled;

    initial begin
        m_s1 = '0; m_s2 = '0; m_clean = '0; m_pulse = '0;
        m_any = 0; m_settled = 1; m_plaus = 1;
        f_h0 = '0; f_h1 = '0; f_clean = '0; f_pulse = '0; f_settled = 1;
        for (int i = 0; i < NCH; i++) m_ticks[i] = 0;
        forever begin
            @(posedge clock);
            if (reset) begin
                m_s1 = '0; m_s2 = '0; m_clean = '0; m_pulse = '0;
                m_any = 0; m_settled = 1; m_plaus = 1;
                for (int i = 0; i < NCH; i++) m_ticks[i] = 0;
                f_h0 = '0; f_h1 = '0; f_clean = '0; f_pulse = '0; f_settled = 1;
            end else begin
                bit all_zero;
                logic [NCH-1:0] prev;
                m_pulse = '0;
                for (int i = 0; i < NCH; i++) begin
                    if (m_s2[i] == m_clean[i]) m_ticks[i] = 0;
                    else if (sample_tick) begin
                        m_ticks[i] = m_ticks[i] + 1;
                        if (m_ticks[i] == ST) begin
                            m_clean[i] = m_s2[i];
                            m_ticks[i] = 0;
                            m_pulse[i] = 1'b1;
                        end
                    end
                end
                m_s2 = m_s1;
                m_s1 = raw_in;
                all_zero = 1;
                for (int i = 0; i < NCH; i++) if (m_ticks[i] != 0) all_zero = 0;
                m_any     = (m_pulse != '0);
                m_settled = (m_s2 == m_clean) && all_zero;
                m_plaus   = thermo_ok(m_clean[2:0]);
                // Fast instance: clean is simply the raw input three clocks back.
                prev      = f_clean;
                f_clean   = f_h1;
                f_h1      = f_h0;
                f_h0      = raw2;
                f_pulse   = prev ^ f_clean;
                f_settled = (f_h1 == f_clean);
            end
        end
    end

    // Every-cycle comparison and statistics for the directed scenarios.
    logic [NCH-1:0] prev_pulse = '0;
    int pulse_cnt[NCH];
    int any_cnt, both_cnt;
    bit saw_unsettled;

    task automatic clear_stats();
        for (int i = 0; i < NCH; i++) pulse_cnt[i] = 0;
        any_cnt = 0; both_cnt = 0; saw_unsettled = 0;
    endtask

    initial begin
        clear_stats();
        forever begin
            @(negedge clock);
            if (run_checks) begin
                check("clean_out", 32'(clean_out), 32'(m_clean));
                check("change_pulse", 32'(change_pulse), 32'(m_pulse));
                check("any_change", 32'(any_change), 32'(m_any));
                check("settled", 32'(settled), 32'(m_settled));
                check("level_plausible", 32'(level_plausible), 32'(m_plaus));
                check("pulse_repeat", 32'(change_pulse & prev_pulse), 32'd0);
                check("fast_clean", 32'(clean2), 32'(f_clean));
                check("fast_pulse", 32'(pulse2), 32'(f_pulse));
                check("fast_any", 32'(any2), 32'(f_pulse != '0));
                check("fast_settled", 32'(settled2), 32'(f_settled));
                check("fast_plausible", 32'(plaus2), 32'(thermo_ok(f_clean[2:0])));
                prev_pulse = change_pulse;
                for (int i = 0; i < NCH; i++) pulse_cnt[i] += int'(change_pulse[i]);
                any_cnt += int'(any_change);
                if (!settled) saw_unsettled = 1;
                if (change_pulse[1] && change_pulse[4]) both_cnt++;
            end
        end
    end

    // Tick source: every 4 clocks, or random in the final phase.
    bit tick_random = 0;
    int tick_ctr = 0;
    initial begin
        sample_tick = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            tick_ctr++;
            if (tick_random) sample_tick = ($urandom_range(1, 0) == 1);
            else             sample_tick = (tick_ctr % 4 == 0);
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        bit found;
        reset = 1'b1; raw_in = '0; raw2 = '0;
        cycles(3);
        run_checks = 1;
        #4;
        check("rst_clean", 32'(clean_out), 32'd0);
        check("rst_settled", 32'(settled), 32'd1);
        check("rst_plausible", 32'(level_plausible), 32'd1);
        reset = 1'b0;

        // Quiet inputs.
        clear_stats();
        cycles(100);
        check("idle_clean", 32'(clean_out), 32'd0);
        check("idle_pulses", 32'(any_cnt), 32'd0);
        check("idle_settled", 32'(settled), 32'd1);

        // Single clean edge on low water.
        clear_stats();
        raw_in[0] = 1'b1;
        cycles(40);
        check("edge_clean0", 32'(clean_out[0]), 32'd1);
        check("edge_pulse0", 32'(pulse_cnt[0]), 32'd1);
        check("edge_any", 32'(any_cnt), 32'd1);

        // Bouncing earth humidity never accepted.
        clear_stats();
        for (int k = 0; k < 12; k++) begin
            raw_in[3] = ~raw_in[3];
            cycles(5);
        end
        cycles(10);
        check("bounce_clean3", 32'(clean_out[3]), 32'd0);
        check("bounce_pulses", 32'(pulse_cnt[3]), 32'd0);
        check("bounce_unsettled", 32'(saw_unsettled), 32'd1);

        // Implausible water code, then repaired.
        raw_in[2:0] = 3'b110;
        cycles(30);
        check("water_110", 32'(clean_out[2:0]), 32'b110);
        check("water_110_plaus", 32'(level_plausible), 32'd0);
        raw_in[0] = 1'b1;
        cycles(30);
        check("water_111", 32'(clean_out[2:0]), 32'b111);
        check("water_111_plaus", 32'(level_plausible), 32'd1);

        // Reset one tick before acceptance, then simultaneous acceptance.
        raw_in = '0;
        cycles(40);
        raw_in[1] = 1'b1;
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            cycles(1);
            if (m_ticks[1] == ST - 1) found = 1;
        end
        check("reach_count3", 32'(found), 32'd1);
        reset = 1'b1; raw_in[1] = 1'b0;
        cycles(1);
        reset = 1'b0;
        check("midreset_clean", 32'(clean_out), 32'd0);
        check("midreset_settled", 32'(settled), 32'd1);
        clear_stats();
        raw_in[1] = 1'b1; raw_in[4] = 1'b1;
        cycles(40);
        check("pair_clean", 32'(clean_out), 32'b010010);
        check("pair_any_once", 32'(any_cnt), 32'd1);
        check("pair_same_cycle", 32'(both_cnt), 32'd1);

        // Fast instance: exactly three clocks from raw to clean.
        raw2 = 6'b000001;
        cycles(2);
        check("fast_lat2", 32'(clean2[0]), 32'd0);
        cycles(1);
        check("fast_lat3", 32'(clean2[0]), 32'd1);

        // Randomized phase.
        tick_random = 1;
        for (int k = 0; k < 3000; k++) begin
            cycles(1);
            if ($urandom_range(15, 0) == 0) raw_in = NCH'($urandom);
            raw2  = NCH'($urandom);
            reset = ($urandom_range(699, 0) == 0);
        end
        reset = 1'b0;
        cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
